// File: rtl/m_wb_gpio.sv
// Wishbone-classic GPIO: set/clear/toggle outputs, synchronised inputs,
// per-pin edge capture with a level interrupt.
module m_wb_gpio #(
  parameter int              NOUT       = 8,
  parameter int              NIN        = 8,
  parameter int              SYNCSTAGES = 2,
  parameter logic [NOUT-1:0] OUTRESET   = '0
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            CYC_I,
  input  logic            STB_I,
  input  logic            WE_I,
  input  logic [2:0]      ADR_I,
  input  logic [31:0]     DAT_I,
  input  logic [3:0]      SEL_I,
  output logic [31:0]     DAT_O,
  output logic            ACK_O,
  input  logic [NIN-1:0]  pin_i,
  output logic [NOUT-1:0] pin_o,
  output logic            irq_o
);

  localparam logic [2:0] ARMCNT = 3'(SYNCSTAGES + 1);

  logic [NOUT-1:0] out_q, out_d;
  logic [NIN-1:0]  ien_q, ien_d;
  logic [NIN-1:0]  pend_q, pend_d;
  logic [NIN-1:0]  esel_q, esel_d;
  logic [NIN-1:0]  prev_q;
  logic [NIN-1:0]  sync_q [SYNCSTAGES];
  logic [2:0]      arm_q, arm_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;

  logic            req, wr, armed;
  logic [31:0]     wmask, wdat;
  logic [31:0]     out_w, ien_w, pend_w, esel_w, in_w;
  logic [31:0]     out_n, ien_n, esel_n, clr, rdata;
  logic [NIN-1:0]  in_s, evt;
  logic            unused_bits;

  assign in_s   = sync_q[SYNCSTAGES-1];
  assign req    = CYC_I & STB_I & ~ack_q;
  assign wr     = req & WE_I;
  assign wmask  = {{8{SEL_I[3]}}, {8{SEL_I[2]}}, {8{SEL_I[1]}}, {8{SEL_I[0]}}};
  assign wdat   = DAT_I & wmask;
  assign out_w  = 32'(out_q);
  assign ien_w  = 32'(ien_q);
  assign pend_w = 32'(pend_q);
  assign esel_w = 32'(esel_q);
  assign in_w   = 32'(in_s);
  assign armed  = (arm_q == ARMCNT);

  always_comb begin
    out_n  = out_w;
    ien_n  = ien_w;
    esel_n = esel_w;
    clr    = '0;
    if (wr) begin
      case (ADR_I)
        3'd0:    out_n  = (out_w & ~wmask) | wdat;
        3'd1:    out_n  = out_w | wdat;
        3'd2:    out_n  = out_w & ~wdat;
        3'd3:    out_n  = out_w ^ wdat;
        3'd5:    ien_n  = (ien_w & ~wmask) | wdat;
        3'd6:    clr    = wdat;
        3'd7:    esel_n = (esel_w & ~wmask) | wdat;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (ADR_I)
      3'd0:    rdata = out_w;
      3'd4:    rdata = in_w;
      3'd5:    rdata = ien_w;
      3'd6:    rdata = pend_w;
      3'd7:    rdata = esel_w;
      default: rdata = '0;
    endcase
  end

  // Edge detection uses the registered EDGE value, so a write lands next cycle.
  assign evt    = armed ? ((esel_q & prev_q & ~in_s) | (~esel_q & ~prev_q & in_s)) : '0;
  assign pend_d = (pend_q & ~clr[NIN-1:0]) | evt;
  assign out_d  = out_n[NOUT-1:0];
  assign ien_d  = ien_n[NIN-1:0];
  assign esel_d = esel_n[NIN-1:0];
  assign arm_d  = armed ? arm_q : arm_q + 3'd1;
  assign ack_d  = req;
  assign dat_d  = (req & ~WE_I) ? rdata : '0;

  assign unused_bits = ^{out_n, ien_n, esel_n, clr};

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      out_q  <= OUTRESET;
      ien_q  <= '0;
      pend_q <= '0;
      esel_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      for (int i = 0; i < SYNCSTAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q  <= out_d;
      ien_q  <= ien_d;
      pend_q <= pend_d;
      esel_q <= esel_d;
      prev_q <= in_s;
      arm_q  <= arm_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      sync_q[0] <= pin_i;
      for (int i = 1; i < SYNCSTAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign DAT_O = dat_q;
  assign ACK_O = ack_q;
  assign pin_o = out_q;
  assign irq_o = |(pend_q & ien_q);

endmodule

// File: tb/tb_m_wb_gpio.sv
// Directed bench for m_wb_gpio with 16 outputs and 8 inputs.
module tb_m_wb_gpio;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        cyc, stb, we;
  logic [2:0]  adr;
  logic [31:0] dat_i, dat_o;
  logic [3:0]  sel;
  logic        ack;
  logic [7:0]  pin_in;
  logic [15:0] pin_out;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;
  logic        irq_ack;
  logic [15:0] pin_ack;
  int          ack_cnt;

  always #5 clk = ~clk;

  m_wb_gpio #(.NOUT(16), .NIN(8), .SYNCSTAGES(2), .OUTRESET(16'h00A5)) dut (
    .CLK_I(clk), .RST_I(rst_b), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .DAT_I(dat_i), .SEL_I(sel), .DAT_O(dat_o), .ACK_O(ack),
    .pin_i(pin_in), .pin_o(pin_out), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) cyc1();
  endtask

  task automatic wb(input logic w, input logic [2:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    cyc1();
    check("ack_rise", {31'd0, ack}, 32'd1);
    r       = dat_o;
    irq_ack = irq;
    pin_ack = pin_out;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cyc1();
    check("ack_1cyc", {31'd0, ack}, 32'd0);
    check("dat_idle", dat_o, 32'd0);
  endtask

  initial begin
    rst_b = 1'b0; cyc = 0; stb = 0; we = 0; adr = 0; dat_i = 0; sel = 0;
    pin_in = 8'hFF;
    wait_n(3);
    check("rst_pin_o", {16'd0, pin_out}, 32'h00A5);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_b = 1'b1;
    wait_n(20);
    wb(0, 3'd6, 0, 4'hF, rd); check("arm_pend", rd, 32'd0);
    check("arm_irq", {31'd0, irq}, 32'd0);
    wb(0, 3'd4, 0, 4'hF, rd); check("in_ff", rd, 32'h000000FF);

    // Output write modes
    wb(1, 3'd0, 32'h0F, 4'hF, rd); check("out_0f", {16'd0, pin_ack}, 32'h000F);
    wb(1, 3'd1, 32'hF0, 4'hF, rd); check("set_ff", {16'd0, pin_ack}, 32'h00FF);
    wb(1, 3'd2, 32'h03, 4'hF, rd); check("clr_fc", {16'd0, pin_ack}, 32'h00FC);
    wb(1, 3'd3, 32'h81, 4'hF, rd); check("tgl_7d", {16'd0, pin_ack}, 32'h007D);
    wb(1, 3'd0, 32'h0000AA55, 4'b0010, rd);
    check("sel_byte1", {16'd0, pin_ack}, 32'hAA7D);
    wb(1, 3'd0, 32'hFFFFFFFF, 4'b1100, rd);
    wb(0, 3'd0, 0, 4'hF, rd); check("out_rd_hi0", rd, 32'h0000AA7D);
    wb(1, 3'd1, 32'hFFFFFFFF, 4'b0000, rd);
    check("set_nosel", {16'd0, pin_ack}, 32'hAA7D);
    wb(0, 3'd1, 0, 4'hF, rd); check("wo_rd0", rd, 32'd0);
    wb(1, 3'd4, 32'h0, 4'hF, rd);
    wb(0, 3'd4, 0, 4'hF, rd); check("in_wr_ign", rd, 32'h000000FF);

    // Held strobe: one access every two cycles
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd0; ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin cyc1(); if (ack) ack_cnt++; end
    cyc = 1'b0; stb = 1'b0;
    cyc1();
    check("held_stb_acks", ack_cnt, 32'd2);

    // Rising edge on bit 3 with interrupt enabled
    pin_in = 8'hF6;
    wait_n(5);
    wb(0, 3'd6, 0, 4'hF, rd); check("fall_no_evt", rd, 32'd0);
    wb(1, 3'd5, 32'h08, 4'hF, rd);
    pin_in = 8'hFE;
    cyc1();
    cyc1(); check("irq_t1", {31'd0, irq}, 32'd0);
    cyc1(); check("irq_t2", {31'd0, irq}, 32'd1);
    wb(0, 3'd6, 0, 4'hF, rd); check("pend_b3", rd, 32'h08);
    wb(0, 3'd4, 0, 4'hF, rd); check("in_fe", rd, 32'hFE);
    wb(1, 3'd6, 32'h08, 4'hF, rd); check("irq_clr", {31'd0, irq_ack}, 32'd0);
    wb(0, 3'd6, 0, 4'hF, rd); check("pend_clr", rd, 32'd0);

    // Falling-edge select on bit 0
    wb(1, 3'd7, 32'h01, 4'hF, rd);
    wb(0, 3'd7, 0, 4'hF, rd); check("edge_rd", rd, 32'h01);
    pin_in = 8'hFF; wait_n(5);
    wb(0, 3'd6, 0, 4'hF, rd); check("rise_ign", rd, 32'd0);
    pin_in = 8'hFE; wait_n(5);
    wb(0, 3'd6, 0, 4'hF, rd); check("fall_evt", rd, 32'h01);
    check("irq_masked", {31'd0, irq}, 32'd0);
    wb(1, 3'd5, 32'h09, 4'hF, rd); check("ien_pending", {31'd0, irq_ack}, 32'd1);
    wb(1, 3'd5, 32'h08, 4'hF, rd);
    wb(1, 3'd6, 32'h01, 4'hF, rd);
    wb(0, 3'd6, 0, 4'hF, rd); check("pend0_clr", rd, 32'd0);
    pin_in = 8'hFF; wait_n(5);
    pin_in = 8'hFE;
    cyc1(); cyc1();
    wb(1, 3'd6, 32'h01, 4'hF, rd);
    wb(0, 3'd6, 0, 4'hF, rd); check("set_wins", rd, 32'h01);

    // Reset during a write
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd0; dat_i = 32'h1234; sel = 4'hF;
    rst_b = 1'b0;
    cyc1();
    check("rstw_ack", {31'd0, ack}, 32'd0);
    check("rstw_out", {16'd0, pin_out}, 32'h00A5);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_b = 1'b1;
    cyc1();
    check("post_rst_ack", {31'd0, ack}, 32'd0);
    check("post_rst_dat", dat_o, 32'd0);
    wb(0, 3'd7, 0, 4'hF, rd); check("rst_edge", rd, 32'd0);
    wb(0, 3'd5, 0, 4'hF, rd); check("rst_ien", rd, 32'd0);
    wb(0, 3'd0, 0, 4'hF, rd); check("rst_out_rd", rd, 32'h00A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
